// File: rtl/programmable_pulse_divider.sv
// programmable_pulse_divider: reloadable up-counter that emits a tick per period
// and a 50% divided clock; the load value is only taken at period boundaries.
module programmable_pulse_divider #(
   parameter int             W          = 8,
   parameter logic [W-1:0]   RESET_LOAD = 8'hFE,
   parameter int             CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   input  logic [W-1:0]     load_val,
   output logic [W-1:0]     cur_load,
   output logic [W-1:0]     cnt,
   output logic             tick,
   output logic             div_clk,
   output logic [CNT_W-1:0] tick_count
);
   logic [W-1:0]     cnt_q, cnt_d;
   logic [W-1:0]     cur_load_q, cur_load_d;
   logic             tick_q, tick_d;
   logic             div_clk_q, div_clk_d;
   logic [CNT_W-1:0] tick_count_q, tick_count_d;
   logic             term;

   assign term = &cnt_q;

   // restart outranks the terminal reload, so a coinciding terminal count yields no tick
   always_comb begin
      cnt_d        = cnt_q;
      cur_load_d   = cur_load_q;
      tick_d       = 1'b0;
      div_clk_d    = div_clk_q;
      tick_count_d = tick_count_q;
      if (restart) begin
         cnt_d      = load_val;
         cur_load_d = load_val;
         div_clk_d  = 1'b0;
      end else if (en) begin
         cnt_d        = term ? load_val : cnt_q + W'(1);
         cur_load_d   = term ? load_val : cur_load_q;
         tick_d       = term;
         div_clk_d    = div_clk_q ^ term;
         tick_count_d = term ? tick_count_q + CNT_W'(1) : tick_count_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= RESET_LOAD;
         cur_load_q   <= RESET_LOAD;
         tick_q       <= 1'b0;
         div_clk_q    <= 1'b0;
         tick_count_q <= '0;
      end else begin
         cnt_q        <= cnt_d;
         cur_load_q   <= cur_load_d;
         tick_q       <= tick_d;
         div_clk_q    <= div_clk_d;
         tick_count_q <= tick_count_d;
      end
   end

   assign cnt        = cnt_q;
   assign cur_load   = cur_load_q;
   assign tick       = tick_q;
   assign div_clk    = div_clk_q;
   assign tick_count = tick_count_q;
endmodule

// File: tb/tb_programmable_pulse_divider.sv
// tb_programmable_pulse_divider: directed stimulus with a tick scoreboard; each expected
// tick carries its spacing from the previous tick (-1 = unchecked), count, div_clk and load.
module tb_programmable_pulse_divider;
   logic        clk, rst, en, restart;
   logic [7:0]  load_val, cur_load, cnt;
   logic        tick, div_clk;
   logic [15:0] tick_count;

   typedef struct {
      int          gap;
      logic [15:0] tc;
      logic        dc;
      logic [7:0]  cl;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   bit   mon_on = 1'b1;

   programmable_pulse_divider dut (
      .clk(clk), .rst(rst), .en(en), .restart(restart), .load_val(load_val),
      .cur_load(cur_load), .cnt(cnt), .tick(tick), .div_clk(div_clk),
      .tick_count(tick_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic exp_tick(input int gap, input logic [15:0] tc, input logic dc, input logic [7:0] cl);
      exp_t e;
      e.gap = gap; e.tc = tc; e.dc = dc; e.cl = cl;
      sb.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // monitor: every observed tick is matched against the oldest expected tick
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_on && !rst && tick) begin
            if (sb.size() == 0) begin
               chk("unexpected_tick", 32'(tick_count), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               if (e.gap >= 0) chk("tick_gap", cyc - last_cyc, e.gap);
               chk("tick_count", 32'(tick_count), 32'(e.tc));
               chk("div_clk", 32'(div_clk), 32'(e.dc));
               chk("cur_load", 32'(cur_load), 32'(e.cl));
            end
            last_cyc = cyc;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; en = 1'b0; restart = 1'b0; load_val = 8'hFE;
      #1;
      chk("rst_cnt", 32'(cnt), 32'hFE);
      chk("rst_cur_load", 32'(cur_load), 32'hFE);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_div_clk", 32'(div_clk), 0);
      chk("rst_tick_count", 32'(tick_count), 0);
      cycles(2);
      // N=2: tick every 2 cycles, div_clk period 4
      rst = 1'b0; en = 1'b1;
      exp_tick(-1, 1, 1, 8'hFE);
      exp_tick(2, 2, 0, 8'hFE);
      exp_tick(2, 3, 1, 8'hFE);
      exp_tick(2, 4, 0, 8'hFE);
      cycles(8);
      // load change mid-period does not disturb the running period
      load_val = 8'hF0;
      exp_tick(2, 5, 1, 8'hF0);
      exp_tick(16, 6, 0, 8'hFA);
      exp_tick(6, 7, 1, 8'hFA);
      cycles(7);
      chk("mid_cnt_f5", 32'(cnt), 32'hF5);
      load_val = 8'hFA;
      cycles(5);
      chk("mid_cnt", 32'(cnt), 32'hFA);
      chk("mid_cur_load", 32'(cur_load), 32'hF0);
      cycles(12);
      // N=1 then N=256
      load_val = 8'hFF;
      exp_tick(6, 8, 0, 8'hFF);
      exp_tick(1, 9, 1, 8'hFF);
      exp_tick(1, 10, 0, 8'hFF);
      exp_tick(1, 11, 1, 8'hFF);
      exp_tick(1, 12, 0, 8'h00);
      exp_tick(256, 13, 1, 8'hF8);
      cycles(9);
      load_val = 8'h00;
      cycles(59);
      load_val = 8'hF8;
      cycles(198);
      // enable gap of 5 cycles delays the tick by exactly 5
      exp_tick(13, 14, 0, 8'hF8);
      cycles(3);
      en = 1'b0;
      cycles(3);
      chk("frz_cnt", 32'(cnt), 32'hFB);
      chk("frz_tick", 32'(tick), 0);
      chk("frz_div_clk", 32'(div_clk), 1);
      cycles(2);
      en = 1'b1;
      cycles(5);
      // restart on terminal count: no tick, div_clk cleared
      cycles(7);
      chk("pre_restart_cnt", 32'(cnt), 32'hFF);
      restart = 1'b1; load_val = 8'hF0;
      cycles(1);
      restart = 1'b0;
      chk("rs_tick", 32'(tick), 0);
      chk("rs_tick_count", 32'(tick_count), 14);
      chk("rs_div_clk", 32'(div_clk), 0);
      chk("rs_cnt", 32'(cnt), 32'hF0);
      chk("rs_cur_load", 32'(cur_load), 32'hF0);
      exp_tick(24, 15, 1, 8'hF0);
      cycles(16);
      // async reset mid-period
      cycles(3);
      #2 rst = 1'b1;
      #1;
      chk("arst_cnt", 32'(cnt), 32'hFE);
      chk("arst_cur_load", 32'(cur_load), 32'hFE);
      chk("arst_div_clk", 32'(div_clk), 0);
      chk("arst_tick_count", 32'(tick_count), 0);
      exp_tick(-1, 1, 1, 8'hF0);
      exp_tick(16, 2, 0, 8'hF0);
      @(negedge clk);
      rst = 1'b0;
      cycles(2);
      chk("post_rst_tick", 32'(tick), 1);
      chk("post_rst_cnt", 32'(cnt), 32'hF0);
      cycles(16);
      cycles(1);
      chk("sb_drained", sb.size(), 0);
      // tick_count wrap with N=1
      mon_on = 1'b0;
      restart = 1'b1; load_val = 8'hFF;
      cycles(1);
      restart = 1'b0;
      chk("wrap_start_tc", 32'(tick_count), 2);
      cycles(65533);
      chk("wrap_ffff", 32'(tick_count), 32'hFFFF);
      cycles(1);
      chk("wrap_zero", 32'(tick_count), 0);
      chk("wrap_tick", 32'(tick), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
